// File: rtl/scoreboard_param.sv
// Register scoreboard: tracks pending results per architectural register and
// arbitrates issue against WAW hazards and write-back port collisions.
module scoreboard_param #(
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NUNITS = 4,
  parameter int UW     = 2,
  parameter int MAXLAT = 5,
  parameter int LW     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_dest,
  input  logic [UW-1:0] issue_unit,
  input  logic [LW-1:0] issue_lat,
  output logic          issue_ready,
  input  logic [AW-1:0] id_op1,
  input  logic [AW-1:0] id_op2,
  input  logic [AW-1:0] id_dest,
  output logic          pend_op1,
  output logic          pend_op2,
  output logic          pend_dest,
  output logic [UW-1:0] unit_op1,
  output logic [UW-1:0] unit_op2,
  output logic [UW-1:0] unit_dest,
  output logic          wb_valid,
  output logic [AW-1:0] wb_reg,
  output logic [UW-1:0] wb_unit,
  output logic [AW:0]   busy_cnt
);

  if ((1 << UW) < NUNITS) begin : g_bad_uw
    $error("UW too narrow for NUNITS");
  end
  if ((1 << LW) <= MAXLAT) begin : g_bad_lw
    $error("LW too narrow for MAXLAT");
  end
  if ((1 << AW) < NREGS) begin : g_bad_aw
    $error("AW too narrow for NREGS");
  end

  logic              pend_q [NREGS];
  logic              pend_d [NREGS];
  logic [UW-1:0]     unit_q [NREGS];
  logic [UW-1:0]     unit_d [NREGS];
  logic [MAXLAT-1:0] pos_q  [NREGS];
  logic [MAXLAT-1:0] pos_d  [NREGS];

  logic          pend_op1_q, pend_op2_q, pend_dest_q;
  logic          pend_op1_d, pend_op2_d, pend_dest_d;
  logic [UW-1:0] unit_op1_q, unit_op2_q, unit_dest_q;
  logic [UW-1:0] unit_op1_d, unit_op2_d, unit_dest_d;

  logic [MAXLAT-1:0] res_bus;
  logic [MAXLAT-1:0] issue_pos;
  logic              lat_ok;
  logic              waw_ok;
  logic              slot_free;
  logic              issue_fire;

  // Write-back bus view: every in-flight result occupies exactly one slot.
  always_comb begin
    res_bus  = '0;
    wb_reg   = '0;
    wb_unit  = '0;
    busy_cnt = '0;
    for (int r = 0; r < NREGS; r++) begin
      res_bus  = res_bus | pos_q[r];
      busy_cnt = busy_cnt + (AW + 1)'(pend_q[r]);
      if (pos_q[r][0]) begin
        wb_reg  = AW'(r);
        wb_unit = unit_q[r];
      end
    end
    wb_valid = res_bus[0];
  end

  // Slot lat after this edge's shift lands at lat-1; the top slot is always free.
  always_comb begin
    lat_ok    = (issue_lat != '0) && (issue_lat <= LW'(MAXLAT));
    waw_ok    = (issue_dest == '0) || !pend_q[issue_dest];
    slot_free = 1'b1;
    for (int i = 1; i < MAXLAT; i++) begin
      if ((issue_lat == LW'(i)) && res_bus[i]) begin
        slot_free = 1'b0;
      end
    end
    issue_ready = lat_ok && waw_ok && slot_free;
    issue_fire  = issue_valid && issue_ready && (issue_dest != '0);
    issue_pos   = MAXLAT'(1) << (issue_lat - LW'(1));
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_q[r];
      unit_d[r] = unit_q[r];
      pos_d[r]  = pos_q[r] >> 1;
      if (pos_q[r][0]) begin
        pend_d[r] = 1'b0;
        unit_d[r] = '0;
        pos_d[r]  = '0;
      end
      if (issue_fire && (issue_dest == AW'(r))) begin
        pend_d[r] = 1'b1;
        unit_d[r] = issue_unit;
        pos_d[r]  = issue_pos;
      end
      if (flush || (r == 0)) begin
        pend_d[r] = 1'b0;
        unit_d[r] = '0;
        pos_d[r]  = '0;
      end
    end
  end

  // Lookups sample the pre-update state, so a retiring entry still reads pending.
  always_comb begin
    pend_op1_d  = (id_op1 != '0) && pend_q[id_op1];
    pend_op2_d  = (id_op2 != '0) && pend_q[id_op2];
    pend_dest_d = (id_dest != '0) && pend_q[id_dest];
    unit_op1_d  = (id_op1 != '0) ? unit_q[id_op1] : '0;
    unit_op2_d  = (id_op2 != '0) ? unit_q[id_op2] : '0;
    unit_dest_d = (id_dest != '0) ? unit_q[id_dest] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= 1'b0;
        unit_q[r] <= '0;
        pos_q[r]  <= '0;
      end
      pend_op1_q  <= 1'b0;
      pend_op2_q  <= 1'b0;
      pend_dest_q <= 1'b0;
      unit_op1_q  <= '0;
      unit_op2_q  <= '0;
      unit_dest_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= pend_d[r];
        unit_q[r] <= unit_d[r];
        pos_q[r]  <= pos_d[r];
      end
      pend_op1_q  <= pend_op1_d;
      pend_op2_q  <= pend_op2_d;
      pend_dest_q <= pend_dest_d;
      unit_op1_q  <= unit_op1_d;
      unit_op2_q  <= unit_op2_d;
      unit_dest_q <= unit_dest_d;
    end
  end

  assign pend_op1  = pend_op1_q;
  assign pend_op2  = pend_op2_q;
  assign pend_dest = pend_dest_q;
  assign unit_op1  = unit_op1_q;
  assign unit_op2  = unit_op2_q;
  assign unit_dest = unit_dest_q;

endmodule

// File: tb/tb_scoreboard_param.sv
// Directed, table-driven bench for scoreboard_param with hand-computed expectations.
module tb_scoreboard_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       issue_valid;
  logic [4:0] issue_dest;
  logic [1:0] issue_unit;
  logic [2:0] issue_lat;
  logic       issue_ready;
  logic [4:0] id_op1, id_op2, id_dest;
  logic       pend_op1, pend_op2, pend_dest;
  logic [1:0] unit_op1, unit_op2, unit_dest;
  logic       wb_valid;
  logic [4:0] wb_reg;
  logic [1:0] wb_unit;
  logic [5:0] busy_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scoreboard_param dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_unit(issue_unit),
    .issue_lat(issue_lat), .issue_ready(issue_ready),
    .id_op1(id_op1), .id_op2(id_op2), .id_dest(id_dest),
    .pend_op1(pend_op1), .pend_op2(pend_op2), .pend_dest(pend_dest),
    .unit_op1(unit_op1), .unit_op2(unit_op2), .unit_dest(unit_dest),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_unit(wb_unit),
    .busy_cnt(busy_cnt)
  );

  typedef struct {
    logic       fl, v;
    logic [4:0] dest;
    logic [1:0] unit;
    logic [2:0] lat;
    logic [4:0] id1, id2, idd;
    logic       rdy, wbv;
    logic [4:0] wbr;
    logic [1:0] wbu;
    logic [5:0] busy;
    logic       p1;
    logic [1:0] u1;
    logic       p2;
    logic [1:0] u2;
    logic       pd;
    logic [1:0] ud;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int fl, int v, int dest, int unit, int lat,
                              int id1, int id2, int idd,
                              int rdy, int wbv, int wbr, int wbu, int busy,
                              int p1, int u1, int p2, int u2, int pd, int ud);
    vec_t t;
    t.fl = fl[0]; t.v = v[0]; t.dest = dest[4:0]; t.unit = unit[1:0]; t.lat = lat[2:0];
    t.id1 = id1[4:0]; t.id2 = id2[4:0]; t.idd = idd[4:0];
    t.rdy = rdy[0]; t.wbv = wbv[0]; t.wbr = wbr[4:0]; t.wbu = wbu[1:0]; t.busy = busy[5:0];
    t.p1 = p1[0]; t.u1 = u1[1:0]; t.p2 = p2[0]; t.u2 = u2[1:0]; t.pd = pd[0]; t.ud = ud[1:0];
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic v, input logic [4:0] d,
                       input logic [1:0] u, input logic [2:0] l);
    flush = fl; issue_valid = v; issue_dest = d; issue_unit = u; issue_lat = l;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 1);
    id_op1 = 0; id_op2 = 0; id_dest = 0;
    #1;
    chk("reset_busy", busy_cnt, 0);
    chk("reset_wbv", wb_valid, 0);
    chk("reset_ready", issue_ready, 1);
    chk("reset_pend_op1", pend_op1, 0);
    @(negedge clk);
    rst = 1'b0;

    // fl v dest unit lat | id1 id2 idd | rdy wbv wbr wbu busy | p1 u1 p2 u2 pd ud
    vecs.push_back(mk(0,1,5,1,1, 5,0,5, 1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,5,0,1, 5,0,5, 0,1,5,1,1, 1,1,0,0,1,1));
    vecs.push_back(mk(0,0,5,0,1, 5,0,5, 1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,3,2,3, 3,3,3, 1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,3,0,1, 3,3,3, 0,0,0,0,1, 1,2,1,2,1,2));
    vecs.push_back(mk(0,1,3,0,1, 3,3,3, 0,0,0,0,1, 1,2,1,2,1,2));
    vecs.push_back(mk(0,1,3,0,1, 3,3,3, 0,1,3,2,1, 1,2,1,2,1,2));
    vecs.push_back(mk(0,1,3,0,1, 3,3,3, 1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,3,0,1, 3,3,3, 0,1,3,0,1, 1,0,1,0,1,0));
    vecs.push_back(mk(0,1,0,2,2, 0,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,6, 0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,5, 0,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,7, 0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,7,1,3, 7,2,1, 1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,2,2,4, 7,2,1, 1,0,0,0,1, 1,1,0,0,0,0));
    vecs.push_back(mk(0,1,1,3,5, 7,2,1, 1,0,0,0,2, 1,1,1,2,0,0));
    vecs.push_back(mk(1,1,9,0,1, 7,2,1, 1,1,7,1,3, 1,1,1,2,1,3));
    vecs.push_back(mk(0,0,9,0,1, 9,2,1, 1,0,0,0,0, 0,0,0,0,0,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0,0,0,1, 0,0,0, 1,0,0,0,0, 0,0,0,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].v, vecs[i].dest, vecs[i].unit, vecs[i].lat);
      id_op1 = vecs[i].id1; id_op2 = vecs[i].id2; id_dest = vecs[i].idd;
      #1;
      $display("vec %0d: fl=%0d v=%0d dest=%0d lat=%0d ready=%0d wbv=%0d wbr=%0d busy=%0d",
               i, vecs[i].fl, vecs[i].v, vecs[i].dest, vecs[i].lat,
               issue_ready, wb_valid, wb_reg, busy_cnt);
      chk($sformatf("v%0d_ready", i), issue_ready, vecs[i].rdy);
      chk($sformatf("v%0d_wbv", i), wb_valid, vecs[i].wbv);
      chk($sformatf("v%0d_wbr", i), wb_reg, vecs[i].wbr);
      chk($sformatf("v%0d_wbu", i), wb_unit, vecs[i].wbu);
      chk($sformatf("v%0d_busy", i), busy_cnt, vecs[i].busy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_p1", i), pend_op1, vecs[i].p1);
      chk($sformatf("v%0d_u1", i), unit_op1, vecs[i].u1);
      chk($sformatf("v%0d_p2", i), pend_op2, vecs[i].p2);
      chk($sformatf("v%0d_u2", i), unit_op2, vecs[i].u2);
      chk($sformatf("v%0d_pd", i), pend_dest, vecs[i].pd);
      chk($sformatf("v%0d_ud", i), unit_dest, vecs[i].ud);
      @(negedge clk);
    end

    // Collision stall: lat=2 hits reg 4's slot, lat=3 in the same cycle is taken.
    drive(0, 1, 4, 3, 3);
    #1 chk("col_first_ready", issue_ready, 1);
    @(posedge clk); @(negedge clk);
    drive(0, 1, 6, 1, 2);
    #1 chk("col_lat2_ready", issue_ready, 0);
    issue_lat = 3;
    #1 chk("col_lat3_ready", issue_ready, 1);
    $display("collision: dest6 lat3 ready=%0d", issue_ready);
    @(posedge clk); @(negedge clk);
    drive(0, 0, 0, 0, 1);
    #1 chk("col_busy", busy_cnt, 2);
    chk("col_wbv0", wb_valid, 0);
    @(posedge clk); @(negedge clk);
    #1 chk("col_wbv1", wb_valid, 1);
    chk("col_wbr1", wb_reg, 4);
    chk("col_wbu1", wb_unit, 3);
    @(posedge clk); @(negedge clk);
    #1 chk("col_wbv2", wb_valid, 1);
    chk("col_wbr2", wb_reg, 6);
    chk("col_wbu2", wb_unit, 1);
    @(posedge clk); @(negedge clk);
    #1 chk("col_wbv3", wb_valid, 0);
    chk("col_busy_end", busy_cnt, 0);

    // Mid-flight asynchronous reset discards reservations.
    @(negedge clk);
    drive(0, 1, 1, 2, 5);
    id_op1 = 1; id_op2 = 2; id_dest = 1;
    @(posedge clk); @(negedge clk);
    drive(0, 1, 2, 3, 5);
    #1 chk("rst_issue2_ready", issue_ready, 1);
    @(posedge clk); @(negedge clk);
    drive(0, 0, 1, 0, 5);
    @(posedge clk);
    #1 chk("rst_pre_p1", pend_op1, 1);
    chk("rst_pre_u2", unit_op2, 3);
    chk("rst_pre_busy", busy_cnt, 2);
    #2 rst = 1'b1;
    #1;
    $display("async reset: busy=%0d pend_op1=%0d pend_op2=%0d", busy_cnt, pend_op1, pend_op2);
    chk("rst_busy", busy_cnt, 0);
    chk("rst_p1", pend_op1, 0);
    chk("rst_u1", unit_op1, 0);
    chk("rst_p2", pend_op2, 0);
    chk("rst_u2", unit_op2, 0);
    chk("rst_pd", pend_dest, 0);
    chk("rst_ud", unit_dest, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_ready", issue_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("post_rst_wbv%0d", k), wb_valid, 0);
      chk($sformatf("post_rst_busy%0d", k), busy_cnt, 0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
